// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and defaults for the uart_rx block
`timescale 1ns/1ps
package uart_rx_pkg;

  localparam int OVERSAMPLING_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_baud_tick.sv
// rtl/uart_rx_baud_tick.sv - fractional divider producing one-clk ticks at Baud*Oversampling
`timescale 1ns/1ps
module uart_rx_baud_tick
  import uart_rx_pkg::*;
#(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = OVERSAMPLING_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [32:0] INC = 33'(Baud * Oversampling);
  localparam logic [32:0] LIM = 33'(ClkFrequency);

  logic [32:0] acc;
  logic [32:0] acc_sum;

  // Phase accumulator keeps the long-run tick rate exact instead of rounding the divisor.
  assign acc_sum = acc + INC;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      if (acc_sum >= LIM) begin
        acc  <= acc_sum - LIM;
        tick <= 1'b1;
      end else begin
        acc  <= acc_sum;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 UART receiver with glitch filter and idle detection
`timescale 1ns/1ps
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int ClkFrequency = 25000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = OVERSAMPLING_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_data_ready,
  output logic       rx_frame_error,
  output logic       rx_idle,
  output logic       rx_endofpacket
);

  localparam int CW = $clog2(Oversampling);
  localparam int GW = $clog2(2 * Oversampling) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(Oversampling / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(Oversampling - 1);
  localparam logic [GW-1:0] GAP_SAT   = GW'(2 * Oversampling);
  localparam logic [GW-1:0] GAP_LAST  = GW'(2 * Oversampling - 1);

  logic          tick;
  logic [1:0]    sync_q;
  logic [1:0]    filt_cnt;
  logic [1:0]    filt_cnt_next;
  logic          filt;
  rx_state_t     state;
  rx_state_t     state_next;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [GW-1:0] gap;

  logic cnt_clr;
  logic cnt_inc;
  logic sample_bit;
  logic good_stop;
  logic bad_stop;

  uart_rx_baud_tick #(
    .ClkFrequency(ClkFrequency),
    .Baud        (Baud),
    .Oversampling(Oversampling)
  ) u_baud_tick (
    .clk   (clk),
    .reset (~rst_n),
    .enable(1'b1),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      filt_cnt <= 2'd3;
      filt     <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx};
      if (tick) begin
        filt_cnt <= filt_cnt_next;
        if (filt_cnt_next == 2'd3) begin
          filt <= 1'b1;
        end else if (filt_cnt_next == 2'd0) begin
          filt <= 1'b0;
        end
      end
    end
  end

  // Saturating majority-style filter: the output only flips after three consistent ticks.
  always_comb begin
    filt_cnt_next = filt_cnt;
    if (sync_q[1] && filt_cnt != 2'd3) begin
      filt_cnt_next = filt_cnt + 2'd1;
    end else if (!sync_q[1] && filt_cnt != 2'd0) begin
      filt_cnt_next = filt_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      shift          <= '0;
      rx_data        <= '0;
      rx_data_ready  <= 1'b0;
      rx_frame_error <= 1'b0;
    end else begin
      state <= state_next;
      if (cnt_clr) begin
        tick_cnt <= '0;
      end else if (cnt_inc) begin
        tick_cnt <= tick_cnt + 1'b1;
      end
      if (sample_bit) begin
        shift   <= {filt, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (good_stop) begin
        rx_data <= shift;
      end
      rx_data_ready  <= good_stop;
      rx_frame_error <= bad_stop;
    end
  end

  always_comb begin
    state_next = state;
    if (tick) begin
      case (state)
        IDLE:  if (!filt) state_next = START;
        START: if (tick_cnt == HALF_LAST) state_next = filt ? IDLE : DATA;
        DATA:  if (tick_cnt == BIT_LAST && bit_cnt == 3'd7) state_next = STOP;
        STOP:  if (tick_cnt == BIT_LAST) state_next = filt ? IDLE : BREAK;
        BREAK: if (filt) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // The filter delays edges by a few ticks, so sampling relative to the filtered start edge lands mid-bit.
  always_comb begin
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    sample_bit = 1'b0;
    good_stop  = 1'b0;
    bad_stop   = 1'b0;
    if (tick) begin
      case (state)
        IDLE: cnt_clr = 1'b1;
        START: begin
          if (tick_cnt == HALF_LAST) cnt_clr = 1'b1;
          else                       cnt_inc = 1'b1;
        end
        DATA: begin
          if (tick_cnt == BIT_LAST) begin
            cnt_clr    = 1'b1;
            sample_bit = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == BIT_LAST) begin
            cnt_clr   = 1'b1;
            good_stop = filt;
            bad_stop  = ~filt;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap            <= GAP_SAT;
      rx_endofpacket <= 1'b0;
    end else begin
      rx_endofpacket <= 1'b0;
      if (!filt) begin
        gap <= '0;
      end else if (tick && state == IDLE && gap != GAP_SAT) begin
        gap            <= gap + 1'b1;
        rx_endofpacket <= (gap == GAP_LAST);
      end
    end
  end

  assign rx_idle = (gap == GAP_SAT);

endmodule
